// File: rtl/if_id_ex_mem_pipeline_regs.sv
// IF/ID, ID/EX and EX/MEM boundary registers for the front of the ARM pipeline.
// IF/ID carries the fetched instruction and can be stalled; ID/EX and EX/MEM
// carry control bits and always advance. An all-zero control vector is a bubble.
module if_id_ex_mem_pipeline_regs #(
    parameter int INSTR_W = 32
) (
    input  logic               Clk,
    input  logic               Reset,
    // IF/ID
    input  logic               IF_ID_enable,
    input  logic [INSTR_W-1:0] IF_instruction,
    output logic [INSTR_W-1:0] ID_instruction,
    // ID/EX inputs
    input  logic               ID_S_instr,
    input  logic [3:0]         ID_alu_op,
    input  logic               ID_load_instr,
    input  logic               ID_RF_enable,
    input  logic               ID_load_store_instr,
    input  logic               ID_size,
    input  logic               ID_BL_instr,
    input  logic               ID_B_instr,
    input  logic [1:0]         ID_shift_AM,
    // ID/EX outputs
    output logic               EX_S_instr,
    output logic [3:0]         EX_alu_op,
    output logic               EX_load_instr,
    output logic               EX_RF_enable,
    output logic               EX_load_store_instr,
    output logic               EX_size,
    output logic               EX_BL_instr,
    output logic               EX_B_instr,
    output logic [1:0]         EX_shift_AM,
    // EX/MEM outputs
    output logic               MEM_load_instr,
    output logic               MEM_load_store_instr,
    output logic               MEM_size,
    output logic               MEM_RF_enable
);

    // Control word layout shared by the ID/EX stage:
    // {S, alu_op[3:0], load, RF, load_store, size, BL, B, shift_AM[1:0]}
    localparam int EX_CTRL_W  = 13;
    // EX/MEM only keeps the memory/writeback subset: {load, load_store, size, RF}
    localparam int MEM_CTRL_W = 4;

    logic [INSTR_W-1:0]    id_instr_q,  id_instr_d;
    logic [EX_CTRL_W-1:0]  ex_ctrl_q,   ex_ctrl_d;
    logic [MEM_CTRL_W-1:0] mem_ctrl_q,  mem_ctrl_d;

    // Next-state: IF/ID holds when stalled; ID/EX and EX/MEM always advance.
    always_comb begin
        id_instr_d = id_instr_q;
        if (IF_ID_enable) begin
            id_instr_d = IF_instruction;
        end
        ex_ctrl_d  = {ID_S_instr, ID_alu_op, ID_load_instr, ID_RF_enable,
                      ID_load_store_instr, ID_size, ID_BL_instr, ID_B_instr,
                      ID_shift_AM};
        // EX/MEM is fed from the registered EX_ values, never from the ID_ inputs.
        mem_ctrl_d = {EX_load_instr, EX_load_store_instr, EX_size, EX_RF_enable};
    end

    // Boundary registers; reset clears all three stages on the same edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            id_instr_q <= '0;
            ex_ctrl_q  <= '0;
            mem_ctrl_q <= '0;
        end else begin
            id_instr_q <= id_instr_d;
            ex_ctrl_q  <= ex_ctrl_d;
            mem_ctrl_q <= mem_ctrl_d;
        end
    end

    assign ID_instruction = id_instr_q;

    assign {EX_S_instr, EX_alu_op, EX_load_instr, EX_RF_enable,
            EX_load_store_instr, EX_size, EX_BL_instr, EX_B_instr,
            EX_shift_AM} = ex_ctrl_q;

    assign {MEM_load_instr, MEM_load_store_instr, MEM_size, MEM_RF_enable} = mem_ctrl_q;

endmodule

// File: tb/tb_if_id_ex_mem_pipeline_regs.sv
// Directed bench for the IF/ID, ID/EX, EX/MEM boundary registers.
module tb_if_id_ex_mem_pipeline_regs;

    logic        Clk;
    logic        Reset;
    logic        IF_ID_enable;
    logic [31:0] IF_instruction;
    logic [31:0] ID_instruction;
    logic        ID_S_instr, ID_load_instr, ID_RF_enable, ID_load_store_instr;
    logic        ID_size, ID_BL_instr, ID_B_instr;
    logic [3:0]  ID_alu_op;
    logic [1:0]  ID_shift_AM;
    logic        EX_S_instr, EX_load_instr, EX_RF_enable, EX_load_store_instr;
    logic        EX_size, EX_BL_instr, EX_B_instr;
    logic [3:0]  EX_alu_op;
    logic [1:0]  EX_shift_AM;
    logic        MEM_load_instr, MEM_load_store_instr, MEM_size, MEM_RF_enable;

    int tests_run;
    int tests_failed;

    // Control vector layout: {S, alu_op[3:0], load, RF, ls, size, BL, B, shift[1:0]}
    localparam logic [12:0] CTRL_ZERO = 13'h0;
    localparam logic [12:0] CTRL_ALU  = {1'b1, 4'b0100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11};
    localparam logic [12:0] CTRL_LOAD = {1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00};
    localparam logic [12:0] CTRL_ONES = 13'h1FFF;

    if_id_ex_mem_pipeline_regs #(.INSTR_W(32)) dut (
        .Clk                 (Clk),
        .Reset               (Reset),
        .IF_ID_enable        (IF_ID_enable),
        .IF_instruction      (IF_instruction),
        .ID_instruction      (ID_instruction),
        .ID_S_instr          (ID_S_instr),
        .ID_alu_op           (ID_alu_op),
        .ID_load_instr       (ID_load_instr),
        .ID_RF_enable        (ID_RF_enable),
        .ID_load_store_instr (ID_load_store_instr),
        .ID_size             (ID_size),
        .ID_BL_instr         (ID_BL_instr),
        .ID_B_instr          (ID_B_instr),
        .ID_shift_AM         (ID_shift_AM),
        .EX_S_instr          (EX_S_instr),
        .EX_alu_op           (EX_alu_op),
        .EX_load_instr       (EX_load_instr),
        .EX_RF_enable        (EX_RF_enable),
        .EX_load_store_instr (EX_load_store_instr),
        .EX_size             (EX_size),
        .EX_BL_instr         (EX_BL_instr),
        .EX_B_instr          (EX_B_instr),
        .EX_shift_AM         (EX_shift_AM),
        .MEM_load_instr      (MEM_load_instr),
        .MEM_load_store_instr(MEM_load_store_instr),
        .MEM_size            (MEM_size),
        .MEM_RF_enable       (MEM_RF_enable)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Single comparison point: counts, and reports one line per check.
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end else begin
            $display("[TB] ok   %s: %h", tag, obs);
        end
    endtask

    task automatic set_id(input logic [12:0] v);
        {ID_S_instr, ID_alu_op, ID_load_instr, ID_RF_enable, ID_load_store_instr,
         ID_size, ID_BL_instr, ID_B_instr, ID_shift_AM} = v;
    endtask

    function automatic logic [31:0] ex_vec();
        return {19'h0, EX_S_instr, EX_alu_op, EX_load_instr, EX_RF_enable,
                EX_load_store_instr, EX_size, EX_BL_instr, EX_B_instr, EX_shift_AM};
    endfunction

    function automatic logic [31:0] mem_vec();
        return {28'h0, MEM_load_instr, MEM_load_store_instr, MEM_size, MEM_RF_enable};
    endfunction

    // Advance one rising edge and settle before sampling.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;

        // Reset with random inputs: everything must clear.
        Reset          = 1'b1;
        IF_ID_enable   = 1'b1;
        IF_instruction = $urandom;
        set_id(13'($urandom));
        tick();
        check_eq("reset_id_instr", ID_instruction, 32'h0);
        check_eq("reset_ex",       ex_vec(),       32'h0);
        check_eq("reset_mem",      mem_vec(),      32'h0);

        // IF/ID load then stall.
        Reset          = 1'b0;
        set_id(CTRL_ZERO);
        IF_instruction = 32'hE0821003;
        IF_ID_enable   = 1'b1;
        tick();
        check_eq("ifid_load", ID_instruction, 32'hE0821003);
        IF_instruction = 32'hE3A00000;
        IF_ID_enable   = 1'b0;
        tick();
        check_eq("ifid_hold", ID_instruction, 32'hE0821003);

        // ALU op through ID/EX then EX/MEM, followed by a bubble; IF/ID stays stalled.
        set_id(CTRL_ALU);
        tick();
        check_eq("alu_ex",        ex_vec(),       {19'h0, CTRL_ALU});
        check_eq("ifid_hold2",    ID_instruction, 32'hE0821003);
        set_id(CTRL_ZERO);
        tick();
        check_eq("alu_mem",       mem_vec(),      32'h1);   // only RF_enable
        check_eq("bubble_ex",     ex_vec(),       32'h0);
        tick();
        check_eq("bubble_mem",    mem_vec(),      32'h0);

        // Load trio for one cycle: 2-edge latency, 1-cycle width at MEM.
        set_id(CTRL_LOAD);
        tick();
        set_id(CTRL_ZERO);
        check_eq("load_ex",       ex_vec(),       {19'h0, CTRL_LOAD});
        check_eq("load_mem_e1",   mem_vec(),      32'h0);
        tick();
        check_eq("load_mem_e2",   mem_vec(),      32'hE);   // load, ls, size
        check_eq("load_ex_clear", ex_vec(),       32'h0);
        tick();
        check_eq("load_mem_e3",   mem_vec(),      32'h0);

        // Fill all stages with nonzero values, then reset mid-stream.
        set_id(CTRL_ONES);
        IF_instruction = 32'h12345678;
        IF_ID_enable   = 1'b1;
        tick();
        tick();
        check_eq("fill_id",  ID_instruction, 32'h12345678);
        check_eq("fill_ex",  ex_vec(),       {19'h0, CTRL_ONES});
        check_eq("fill_mem", mem_vec(),      32'hF);
        Reset = 1'b1;
        tick();
        check_eq("midrst_id",  ID_instruction, 32'h0);
        check_eq("midrst_ex",  ex_vec(),       32'h0);
        check_eq("midrst_mem", mem_vec(),      32'h0);
        Reset = 1'b0;
        tick();
        check_eq("postrst_id",  ID_instruction, 32'h12345678);
        check_eq("postrst_ex",  ex_vec(),       {19'h0, CTRL_ONES});
        check_eq("postrst_mem", mem_vec(),      32'h0);
        tick();
        check_eq("postrst_mem2", mem_vec(),     32'hF);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
